data_mem_responder: RTL

//  Memory-side responder for the CPU data-memory port. Accepts one read/write

---
 rtl/dmem_pkg.sv | 13 +
 rtl/dmem_array.sv | 31 +++
 rtl/data_mem_responder.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_array.sv
// DEPTH x DATA_W word storage: synchronous write, registered read.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // No reset here so the storage maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[idx] <= wdata;
    end
    if (re) begin
      rdata_q <= mem_q[idx];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: one outstanding access, WAIT_STATES latency, stall.
// Optional address alignment/range checking via `define DMEM_ALIGN_CHECK_EN.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              stall
);

  localparam int               IDX_W    = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] WAIT_CNT = CNT_W'(WAIT_STATES);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               wr_q, wr_d;
  logic [31:0]        addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_err_q, rsp_err_d;
  logic               rd_sel_q, rd_sel_d;

  logic               acc_go;
  logic               acc_write;
  logic [31:0]        acc_addr;
  logic [DATA_W-1:0]  acc_wdata;
  logic               acc_err;
  logic [DATA_W-1:0]  arr_rdata;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err_q;
    rd_sel_d    = rd_sel_q;
    acc_go      = 1'b0;
    acc_write   = wr_q;
    acc_addr    = addr_q;
    acc_wdata   = wdata_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          wr_d    = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (WAIT_STATES == 0) begin
            // Zero latency: access straight from the request inputs.
            acc_go    = 1'b1;
            acc_write = req_write;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
            state_d   = RESP;
          end else begin
            cnt_d   = WAIT_CNT;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == CNT_W'(1)) begin
          acc_go  = 1'b1;
          state_d = RESP;
        end
        cnt_d = cnt_q - CNT_W'(1);
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (acc_go) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = acc_err;
      rd_sel_d    = ~acc_write & ~acc_err;
    end
  end

`ifdef DMEM_ALIGN_CHECK_EN
  assign acc_err = (acc_addr[1:0] != 2'b00) || (acc_addr >= 32'(4 * DEPTH));
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^{acc_addr[31:IDX_W+2], acc_addr[1:0]};
  assign acc_err          = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rd_sel_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rd_sel_q    <= rd_sel_d;
    end
  end

  // Gating with reset keeps an aborted write from landing on the reset edge.
  dmem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (acc_go & acc_write & ~acc_err & ~reset),
    .re    (acc_go & ~acc_write & ~acc_err & ~reset),
    .idx   (acc_addr[IDX_W+1:2]),
    .wdata (acc_wdata),
    .rdata (arr_rdata)
  );

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rd_sel_q ? arr_rdata : '0;
  assign stall     = req_valid & ~rsp_valid_q;

endmodule
